id_ex_lanes: RTL and testbench

Parametrised ID→EX issue register for an N-lane in-order MIPS pipeline. It uses a valid/ready handshake, an optional one-entry skid buffer, and lane-granular flush. It sits between the decode/issue stage and the execute stage. On a branch misprediction it keeps exactly the delay-slot instruction (lane 0 of the group after the branch), even when that group has not arrived yet. It replaces stall-vector bubble insertion with backpressure.

---
 rtl/id_ex_lanes.sv | 216 +++++++++++++++++++++
 tb/tb_id_ex_lanes.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_lanes.sv
// id_ex_lanes: ID->EX issue register for an N-lane in-order MIPS pipeline.
//
// Holds one issued group (output register, OR) for the execute stage. It can
// also hold an optional one-entry skid group (SK), enabled by defining
// ID_EX_LANES_SKID_EN. In the default build the skid is absent and in_ready
// depends combinationally on out_ready.
//
// Handshake: a group moves across an interface on a rising edge where valid
// and ready are both 1. The producer holds valid and its payload stable until
// that edge. Ready may depend on valid, but valid never depends on ready.
//
// Flushes:
//   exception  (flush && !flush_cause): OR, SK, ds_pending and trim clear,
//               and no input is taken.
//   mispredict (flush &&  flush_cause): only the delay-slot instruction
//               survives. It is lane 0 of the group after the branch. If that
//               group has not arrived yet, trim is armed so that the next
//               group loaded is cut down to lane 0.
module id_ex_lanes #(
  parameter int LANES    = 2,
  parameter int LANE_W   = 128,
  parameter int SHARED_W = 72
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_valid,
  input  logic [LANES*LANE_W-1:0]   in_lane_data,
  input  logic [SHARED_W-1:0]       in_shared,
  input  logic                      in_next_ds,
  input  logic                      flush,
  input  logic                      flush_cause,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [LANES*LANE_W-1:0]   out_lane_data,
  output logic [SHARED_W-1:0]       out_shared,
  output logic                      out_ds_pending
);

  localparam logic [LANES-1:0] LANE0_ONLY = LANES'(1);

  // Output register group and the flags that steer it
  logic                    r_or_valid;
  logic [LANES-1:0]        r_or_lane_valid;
  logic [LANES*LANE_W-1:0] r_or_lane_data;
  logic [SHARED_W-1:0]     r_or_shared;
  logic                    r_ds_pending;
  logic                    r_trim;

  logic                    w_exc_flush;
  logic                    w_mis_flush;
  logic                    w_or_free;
  logic                    w_accept;

  // Skid view. In the default build these are tied off.
  logic                    w_sk_valid;
  logic [LANES-1:0]        w_sk_lane_valid;
  logic [LANES*LANE_W-1:0] w_sk_lane_data;
  logic [SHARED_W-1:0]     w_sk_shared;
  logic                    w_sk_next_ds;

  // Candidate group for OR: the skid entry first, then the accepted input
  logic                    w_src_valid;
  logic [LANES-1:0]        w_src_lane_valid;
  logic [LANES*LANE_W-1:0] w_src_lane_data;
  logic [SHARED_W-1:0]     w_src_shared;
  logic                    w_src_next_ds;

  logic                    w_or_load;
  logic                    w_or_clear;
  logic                    w_mask_lane0;
  logic                    w_trim_next;
  logic                    w_ds_next;
  logic [LANES-1:0]        w_ld_lane_valid;
  logic [LANES*LANE_W-1:0] w_ld_lane_data;

  assign w_exc_flush = flush && !flush_cause;
  assign w_mis_flush = flush && flush_cause;
  assign w_or_free   = !r_or_valid || out_ready;
  assign w_accept    = in_valid && in_ready;

`ifdef ID_EX_LANES_SKID_EN
  logic                    r_sk_valid;
  logic [LANES-1:0]        r_sk_lane_valid;
  logic [LANES*LANE_W-1:0] r_sk_lane_data;
  logic [SHARED_W-1:0]     r_sk_shared;
  logic                    r_sk_next_ds;

  // Ready comes from registered skid occupancy, so it has no path from out_ready
  assign in_ready        = !r_sk_valid && !w_exc_flush;
  assign w_sk_valid      = r_sk_valid;
  assign w_sk_lane_valid = r_sk_lane_valid;
  assign w_sk_lane_data  = r_sk_lane_data;
  assign w_sk_shared     = r_sk_shared;
  assign w_sk_next_ds    = r_sk_next_ds;

  // Skid: capture an accepted group when OR is stalled, drain when OR frees
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sk_valid      <= 1'b0;
      r_sk_lane_valid <= '0;
      r_sk_lane_data  <= '0;
      r_sk_shared     <= '0;
      r_sk_next_ds    <= 1'b0;
    end else if (flush) begin
      r_sk_valid <= 1'b0;
    end else if (r_sk_valid) begin
      if (w_or_free) r_sk_valid <= 1'b0;
    end else if (w_accept && !w_or_free) begin
      r_sk_valid      <= 1'b1;
      r_sk_lane_valid <= in_lane_valid;
      r_sk_lane_data  <= in_lane_data;
      r_sk_shared     <= in_shared;
      r_sk_next_ds    <= in_next_ds;
    end
  end
`else
  // Without a skid the input can only be taken when OR frees this edge
  assign in_ready        = w_or_free && !w_exc_flush;
  assign w_sk_valid      = 1'b0;
  assign w_sk_lane_valid = '0;
  assign w_sk_lane_data  = '0;
  assign w_sk_shared     = '0;
  assign w_sk_next_ds    = 1'b0;
`endif

  assign w_src_valid      = w_sk_valid || w_accept;
  assign w_src_lane_valid = w_sk_valid ? w_sk_lane_valid : in_lane_valid;
  assign w_src_lane_data  = w_sk_valid ? w_sk_lane_data  : in_lane_data;
  assign w_src_shared     = w_sk_valid ? w_sk_shared     : in_shared;
  assign w_src_next_ds    = w_sk_valid ? w_sk_next_ds    : in_next_ds;

  // Decide what OR, trim and ds_pending do this edge; flushes override out_ready
  always_comb begin
    w_or_load    = 1'b0;
    w_or_clear   = 1'b0;
    w_mask_lane0 = r_trim;
    w_trim_next  = r_trim;
    w_ds_next    = r_ds_pending;
    if (w_exc_flush) begin
      w_or_clear  = 1'b1;
      w_trim_next = 1'b0;
      w_ds_next   = 1'b0;
    end else if (w_mis_flush) begin
      if (r_ds_pending && w_src_valid) begin
        w_or_load    = 1'b1;
        w_mask_lane0 = 1'b1;
        w_trim_next  = 1'b0;
        w_ds_next    = w_src_next_ds;
      end else begin
        // Delay slot not here yet: arm trim; otherwise just drop the path
        w_or_clear = 1'b1;
        if (r_ds_pending) w_trim_next = 1'b1;
      end
    end else if (w_or_free) begin
      if (w_src_valid) begin
        w_or_load   = 1'b1;
        w_trim_next = 1'b0;
        w_ds_next   = w_src_next_ds;
      end else begin
        w_or_clear = 1'b1;
      end
    end
  end

  // Lane masking on load: trim keeps lane 0 only; empty lanes become NOPs (0)
  always_comb begin
    w_ld_lane_valid = w_mask_lane0 ? (w_src_lane_valid & LANE0_ONLY) : w_src_lane_valid;
    w_ld_lane_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_ld_lane_valid[i]) begin
        w_ld_lane_data[i*LANE_W +: LANE_W] = w_src_lane_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Output register: load a (masked) group or go empty with zeroed payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_or_valid      <= 1'b0;
      r_or_lane_valid <= '0;
      r_or_lane_data  <= '0;
      r_or_shared     <= '0;
    end else if (w_or_load) begin
      r_or_valid      <= 1'b1;
      r_or_lane_valid <= w_ld_lane_valid;
      r_or_lane_data  <= w_ld_lane_data;
      r_or_shared     <= w_src_shared;
    end else if (w_or_clear) begin
      r_or_valid      <= 1'b0;
      r_or_lane_valid <= '0;
      r_or_lane_data  <= '0;
      r_or_shared     <= '0;
    end
  end

  // Delay-slot tracking and pending trim
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ds_pending <= 1'b0;
      r_trim       <= 1'b0;
    end else begin
      r_ds_pending <= w_ds_next;
      r_trim       <= w_trim_next;
    end
  end

  assign out_valid      = r_or_valid;
  assign out_lane_valid = r_or_lane_valid;
  assign out_lane_data  = r_or_lane_data;
  assign out_shared     = r_or_shared;
  assign out_ds_pending = r_ds_pending;

endmodule

// File: tb/tb_id_ex_lanes.sv
// tb_id_ex_lanes: bench for id_ex_lanes. It covers both builds; the skid-only
// checks sit under ID_EX_LANES_SKID_EN. The reference model treats the
// register pair as a short queue: the head is what EX sees, and a second entry
// exists only with the skid.
module tb_id_ex_lanes;

  localparam int LANES    = 2;
  localparam int LANE_W   = 128;
  localparam int SHARED_W = 72;
  localparam int OUT_W    = 1 + LANES + LANES*LANE_W + SHARED_W + 1;
`ifdef ID_EX_LANES_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [LANES-1:0]        lv;
    logic [LANES*LANE_W-1:0] d;
    logic [SHARED_W-1:0]     sh;
    logic                    nds;
  } grp_t;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_lane_valid;
  logic [LANES*LANE_W-1:0] in_lane_data;
  logic [SHARED_W-1:0]     in_shared;
  logic                    in_next_ds;
  logic                    flush;
  logic                    flush_cause;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_lane_valid;
  logic [LANES*LANE_W-1:0] out_lane_data;
  logic [SHARED_W-1:0]     out_shared;
  logic                    out_ds_pending;

  grp_t exp_q[$];
  logic m_ds;
  logic m_trim;
  logic rdy_exp;
  logic rdy_obs;
  int   n_vec;
  int   n_err;

  localparam logic [OUT_W-1:0] ZERO_OUT = '0;

  id_ex_lanes #(.LANES(LANES), .LANE_W(LANE_W), .SHARED_W(SHARED_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_lane_data(in_lane_data),
    .in_shared(in_shared), .in_next_ds(in_next_ds),
    .flush(flush), .flush_cause(flush_cause),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_lane_data(out_lane_data),
    .out_shared(out_shared), .out_ds_pending(out_ds_pending)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Build a group as the stage should hold it: optional trim, empty lanes = 0
  function automatic grp_t make_grp(input logic [LANES-1:0] lv, input logic [LANES*LANE_W-1:0] d,
                                    input logic [SHARED_W-1:0] sh, input logic nds, input logic trim);
    grp_t g;
    g.lv  = trim ? {{(LANES-1){1'b0}}, lv[0]} : lv;
    g.sh  = sh;
    g.nds = nds;
    for (int i = 0; i < LANES; i++) g.d[i*LANE_W +: LANE_W] = g.lv[i] ? d[i*LANE_W +: LANE_W] : '0;
    return g;
  endfunction

  function automatic logic [OUT_W-1:0] dut_out();
    return {out_valid, out_lane_valid, out_lane_data, out_shared, out_ds_pending};
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    grp_t z;
    z = '0;
    if (exp_q.size() > 0) return {1'b1, exp_q[0].lv, exp_q[0].d, exp_q[0].sh, m_ds};
    return {1'b0, z.lv, z.d, z.sh, m_ds};
  endfunction

  function automatic logic model_ready(input logic orr, input logic fl, input logic fc);
    if (fl && !fc) return 1'b0;
    if (CAP == 2) return exp_q.size() < 2;
    return orr || (exp_q.size() == 0);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ds   = 1'b0;
    m_trim = 1'b0;
  endfunction

  // Driver: apply one cycle of inputs, record ready, advance the model on the edge.
  // Called just after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic v, input logic [LANES-1:0] lv, input logic nds,
                      input logic orr, input logic fl, input logic fc, input logic keep);
    grp_t g;
    logic acc;
    logic have;
    logic popped;
    int   was;
    in_valid = v; in_lane_valid = lv; in_next_ds = nds;
    out_ready = orr; flush = fl; flush_cause = fc;
    if (!keep) begin
      for (int k = 0; k < LANES*LANE_W; k++) in_lane_data[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < SHARED_W; k++) in_shared[k] = 1'($urandom_range(0, 1));
    end
    #1;
    rdy_exp = model_ready(orr, fl, fc);
    rdy_obs = in_ready;
    @(posedge clk);
    acc = v && rdy_exp;
    if (fl && !fc) begin
      model_reset();
    end else if (fl) begin
      have = 1'b0;
      g = '0;
      if (exp_q.size() == 2) begin
        g = make_grp(exp_q[1].lv, exp_q[1].d, exp_q[1].sh, exp_q[1].nds, 1'b1);
        have = 1'b1;
      end else if (acc) begin
        g = make_grp(lv, in_lane_data, in_shared, nds, 1'b1);
        have = 1'b1;
      end
      exp_q.delete();
      if (m_ds && have) begin
        exp_q.push_back(g);
        m_ds   = g.nds;
        m_trim = 1'b0;
      end else if (m_ds) begin
        m_trim = 1'b1;
      end
    end else begin
      was = exp_q.size();
      popped = 1'b0;
      if (orr && was > 0) begin
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
      if (acc) begin
        g = make_grp(lv, in_lane_data, in_shared, nds, m_trim && exp_q.size() == 0);
        if (exp_q.size() == 0) m_trim = 1'b0;
        exp_q.push_back(g);
      end
      if ((popped || was == 0) && exp_q.size() > 0) m_ds = exp_q[0].nds;
    end
    #1;
  endtask

  task automatic idle(input logic orr);
    step(1'b0, '0, 1'b0, orr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++; if (dut_out() !== ZERO_OUT) begin n_err++; $display("FAIL reset.out got %h want %h", dut_out(), ZERO_OUT); end
    rst = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [LANES*LANE_W-1:0] d;
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    d = in_lane_data;
    n_vec++; if (rdy_obs !== rdy_exp) begin n_err++; $display("FAIL single.rdy got %b want %b", rdy_obs, rdy_exp); end
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL single.out got %h want %h", dut_out(), model_out()); end
    n_vec++; if ({out_valid, out_lane_valid, out_ds_pending} !== {1'b1, {LANES{1'b1}}, 1'b0}) begin
      n_err++; $display("FAIL single.flags got %b%b%b want 1%b0", out_valid, out_lane_valid, out_ds_pending, {LANES{1'b1}}); end
    n_vec++; if (out_lane_data !== d) begin n_err++; $display("FAIL single.data got %h want %h", out_lane_data, d); end
    idle(1'b1);
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL single.drain got %h want %h", dut_out(), model_out()); end
  endtask

  task automatic test_backpressure();
    logic [LANES*LANE_W-1:0] a_d, b_d, c_d;
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    a_d = in_lane_data;
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL bp.a got %h want %h", dut_out(), model_out()); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    b_d = in_lane_data;
    n_vec++; if (rdy_obs !== rdy_exp) begin n_err++; $display("FAIL bp.rdy_b got %b want %b", rdy_obs, rdy_exp); end
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL bp.b got %h want %h", dut_out(), model_out()); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (rdy_obs !== rdy_exp) begin n_err++; $display("FAIL bp.rdy_c got %b want %b", rdy_obs, rdy_exp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 0) c_d = in_lane_data;
      n_vec++; if (rdy_obs !== rdy_exp) begin n_err++; $display("FAIL bp.rdy_drain%0d got %b want %b", i, rdy_obs, rdy_exp); end
      n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL bp.drain%0d got %h want %h", i, dut_out(), model_out()); end
      in_valid = 1'b0;
    end
`ifdef ID_EX_LANES_SKID_EN
    // Order A, B, C checked against captured payloads: A was out before drain
    n_vec++; if (out_lane_data !== c_d) begin n_err++; $display("FAIL bp.order_c got %h want %h", out_lane_data, c_d); end
    n_vec++; if (a_d === b_d || b_d === c_d) begin n_err++; $display("FAIL bp.distinct got %h want differing payloads", b_d); end
`endif
    idle(1'b1); idle(1'b1);
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL bp.empty got %h want %h", dut_out(), model_out()); end
  endtask

  task automatic test_mispredict_ds();
    logic [LANES*LANE_W-1:0] d;
    step(1'b1, {LANES{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (out_ds_pending !== 1'b1) begin n_err++; $display("FAIL mis_ds.pending got %b want 1", out_ds_pending); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    d = in_lane_data;
    n_vec++; if ({out_valid, out_lane_valid} !== {1'b1, LANES'(1)}) begin
      n_err++; $display("FAIL mis_ds.lanes got %b%b want 1%b", out_valid, out_lane_valid, LANES'(1)); end
    n_vec++; if (out_lane_data[LANES*LANE_W-1:LANE_W] !== '0) begin
      n_err++; $display("FAIL mis_ds.upper got %h want 0", out_lane_data[LANES*LANE_W-1:LANE_W]); end
    n_vec++; if (out_lane_data[LANE_W-1:0] !== d[LANE_W-1:0]) begin
      n_err++; $display("FAIL mis_ds.lane0 got %h want %h", out_lane_data[LANE_W-1:0], d[LANE_W-1:0]); end
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL mis_ds.out got %h want %h", dut_out(), model_out()); end
    idle(1'b1);
  endtask

  task automatic test_mispredict_late();
    step(1'b1, {LANES{1'b1}}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_late.empty got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL mis_late.wait%0d got %h want %h", i, dut_out(), model_out()); end
    end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (out_lane_valid !== LANES'(1)) begin n_err++; $display("FAIL mis_late.d got %b want %b", out_lane_valid, LANES'(1)); end
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL mis_late.d_out got %h want %h", dut_out(), model_out()); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (out_lane_valid !== {LANES{1'b1}}) begin n_err++; $display("FAIL mis_late.next got %b want %b", out_lane_valid, {LANES{1'b1}}); end
    idle(1'b1);
  endtask

  task automatic test_exception();
    step(1'b1, {LANES{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, {LANES{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (out_ds_pending !== 1'b1) begin n_err++; $display("FAIL exc.pre_pending got %b want 1", out_ds_pending); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (rdy_obs !== 1'b0) begin n_err++; $display("FAIL exc.rdy_during got %b want 0", rdy_obs); end
    n_vec++; if ({out_valid, out_ds_pending} !== 2'b00) begin
      n_err++; $display("FAIL exc.after got %b%b want 00", out_valid, out_ds_pending); end
    idle(1'b0);
    n_vec++; if (rdy_obs !== 1'b1) begin n_err++; $display("FAIL exc.rdy_after got %b want 1", rdy_obs); end
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL exc.out got %h want %h", dut_out(), model_out()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), LANES'($urandom_range(0, (1 << LANES) - 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)), 1'b0);
      n_vec++; if (rdy_obs !== rdy_exp) begin n_err++; $display("FAIL rand.rdy%0d got %b want %b", i, rdy_obs, rdy_exp); end
      n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL rand.out%0d got %h want %h", i, dut_out(), model_out()); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, {LANES{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    n_vec++; if (dut_out() !== ZERO_OUT) begin n_err++; $display("FAIL areset.out got %h want %h", dut_out(), ZERO_OUT); end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1'b1);
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL areset.after got %h want %h", dut_out(), model_out()); end
    step(1'b1, {LANES{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (dut_out() !== model_out()) begin n_err++; $display("FAIL areset.resume got %h want %h", dut_out(), model_out()); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; in_valid = 1'b0; in_lane_valid = '0; in_lane_data = '0; in_shared = '0;
    in_next_ds = 1'b0; flush = 1'b0; flush_cause = 1'b0; out_ready = 1'b1;
    rdy_exp = 1'b0; rdy_obs = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_mispredict_ds();
    test_mispredict_late();
    test_exception();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
